// File: rtl/product_bcd_converter.sv
// Sequential double-dabble converter: turns the multiplier's product magnitude and sign
// into packed BCD, one binary bit per clock, with a start/busy/done handshake.
module product_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      mag,
  input  logic                  neg_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]      bin_q, bin_d;
  logic [4*DIGITS-1:0]   scr_q, scr_d;
  logic                  sign_q, sign_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  neg_q, neg_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS-1:0]   shifted;

  always_comb begin
    adj = scr_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    shifted = {adj[4*DIGITS-2:0], bin_q[WIDTH-1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    sign_d  = sign_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d   = mag;
          // A zero magnitude never reports a negative sign.
          sign_d  = neg_in & (|mag);
          scr_d   = '0;
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        scr_d = shifted;
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          bcd_d   = shifted;
          neg_d   = sign_q;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      scr_q   <= '0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      sign_q  <= sign_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd     = bcd_q;
  assign neg_out = neg_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Bench for product_bcd_converter: directed cases plus random magnitudes,
// checked against a decimal-digit reference model.
module tb_product_bcd_converter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] mag;
  logic        neg_in;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic        neg_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [19:0] prev_bcd;
  logic        prev_neg;

  product_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mag     (mag),
    .neg_in  (neg_in),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd),
    .neg_out (neg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] model_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full conversion with a single start pulse; inputs scrambled mid-flight.
  task automatic run_conv(input logic [15:0] m, input logic n);
    int lat;
    logic [19:0] exp_bcd;
    logic        exp_neg;
    exp_bcd = model_bcd(int'(m));
    exp_neg = n && (m != 16'd0);
    @(negedge clk);
    mag = m; neg_in = n; start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == 3) begin
        mag = ~m; neg_in = ~n; start = 1'b1;
      end
      if (lat == 4) start = 1'b0;
      if (lat == 6) begin
        chk("bcd_hold", {12'd0, bcd}, {12'd0, prev_bcd});
        chk("neg_hold", {31'd0, neg_out}, {31'd0, prev_neg});
      end
      step();
      lat++;
    end
    chk("latency", lat, 16);
    chk("bcd", {12'd0, bcd}, {12'd0, exp_bcd});
    chk("neg_out", {31'd0, neg_out}, {31'd0, exp_neg});
    chk("busy_done", {31'd0, busy}, 32'd1);
    step();
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("busy_fall", {31'd0, busy}, 32'd0);
    prev_bcd = exp_bcd;
    prev_neg = exp_neg;
  endtask

  initial begin
    int dones;
    int first_e;
    int second_e;
    logic [15:0] rm;

    rst = 1'b0; start = 1'b0; mag = '0; neg_in = 1'b0;
    prev_bcd = '0; prev_neg = 1'b0;
    step(); step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_bcd", {12'd0, bcd}, 32'd0);
    chk("rst_neg", {31'd0, neg_out}, 32'd0);
    @(negedge clk); rst = 1'b1;

    run_conv(16'd8, 1'b1);
    run_conv(16'd27, 1'b1);
    run_conv(16'd27, 1'b1);
    run_conv(16'hFFFF, 1'b0);
    run_conv(16'd16384, 1'b0);
    run_conv(16'd0, 1'b1);

    // Start held high across a conversion and beyond: exactly one retrigger.
    @(negedge clk);
    mag = 16'd1234; neg_in = 1'b0; start = 1'b1;
    step();
    dones = 0; first_e = -1; second_e = -1;
    for (int e = 1; e <= 40; e++) begin
      if (e == 5) mag = 16'd999;
      step();
      if (done) begin
        dones++;
        if (dones == 1) begin
          first_e = e;
          chk("held_bcd1", {12'd0, bcd}, {12'd0, model_bcd(1234)});
        end else begin
          second_e = e;
          chk("held_bcd2", {12'd0, bcd}, {12'd0, model_bcd(999)});
          start = 1'b0;
        end
      end
    end
    chk("held_dones", dones, 2);
    chk("held_first_edge", first_e, 16);
    chk("held_second_edge", second_e, 34);
    chk("held_idle", {31'd0, busy}, 32'd0);
    prev_bcd = model_bcd(999); prev_neg = 1'b0;

    // Reset in the middle of a conversion aborts it.
    @(negedge clk);
    mag = 16'd4321; neg_in = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e < 8; e++) step();
    @(negedge clk); rst = 1'b0;
    step();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_bcd", {12'd0, bcd}, 32'd0);
    chk("abort_neg", {31'd0, neg_out}, 32'd0);
    @(negedge clk); rst = 1'b1;
    dones = 0;
    for (int e = 0; e < 20; e++) begin
      step();
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    prev_bcd = '0; prev_neg = 1'b0;
    run_conv(16'd555, 1'b1);

    for (int t = 0; t < 25; t++) begin
      case ($urandom_range(0, 7))
        0:       rm = 16'd0;
        1:       rm = 16'hFFFF;
        2:       rm = 16'($urandom_range(0, 99));
        default: rm = 16'($urandom);
      endcase
      run_conv(rm, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
